// File: rtl/tinker_prefetch_queue.sv
// Instruction prefetch queue: credit-limited in-order fetch into a FWFT FIFO,
// with redirect flush that discards responses still in flight.
module tinker_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     mem_req_valid,
  output logic [63:0]              mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [31:0]              mem_resp_data,
  output logic                     inst_valid,
  output logic [31:0]              inst_data,
  output logic [63:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     protocol_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   fetch_pc;
  logic [63:0]   pc_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [63:0]   aq     [DEPTH];
  logic [AW-1:0] head, tail, aq_head, aq_tail;
  logic [CW-1:0] outstanding, drop;
  logic [CW:0]   inflight;
  logic          accept, resp_fire, push, pop;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Credits cover both queued entries and in-flight requests so every
  // response is guaranteed a free slot.
  assign inflight      = {1'b0, count} + {1'b0, outstanding};
  assign mem_req_valid = !reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign accept        = mem_req_valid && mem_req_ready;
  assign resp_fire     = mem_resp_valid && (outstanding != '0);
  assign push          = resp_fire && (drop == '0) && !redirect_valid;
  assign inst_valid    = (count != '0);
  assign pop           = inst_valid && inst_ready && !redirect_valid;
  assign inst_data     = data_q[head];
  assign inst_pc       = pc_q[head];

  always_ff @(posedge clk) begin
    if (accept) aq[aq_tail] <= fetch_pc;
    if (push) begin
      pc_q[tail]   <= aq[aq_head];
      data_q[tail] <= mem_resp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      head         <= '0;
      tail         <= '0;
      aq_head      <= '0;
      aq_tail      <= '0;
      count        <= '0;
      outstanding  <= '0;
      drop         <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (mem_resp_valid && (outstanding == '0)) protocol_err <= 1'b1;
      if (accept)    aq_tail <= aq_tail + 1'b1;
      if (resp_fire) aq_head <= aq_head + 1'b1;
      outstanding <= outstanding + CW'(accept) - CW'(resp_fire);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[63:2], 2'b00};
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        // Every request still in flight after this cycle is stale; drop
        // already-stale ones are a subset, so the total is just outstanding.
        drop     <= outstanding - CW'(resp_fire);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 64'd4;
        if (push)   tail     <= tail + 1'b1;
        if (pop)    head     <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (resp_fire && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tinker_prefetch_queue.sv
// Random-stimulus bench for tinker_prefetch_queue against a queue-based model
// that tags in-flight requests as stale on redirect.
module tb_tinker_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h2000;

  logic        clk, reset;
  logic        redirect_valid, mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [63:0] redirect_pc, mem_req_addr, inst_pc;
  logic [31:0] mem_resp_data, inst_data;
  logic        inst_valid, inst_ready, protocol_err;
  logic [$clog2(DEPTH):0] count;

  tinker_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .count(count), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; bit stale; int cyc; } oq_t;
  typedef struct { logic [63:0] pc; logic [31:0] data; } fe_t;

  oq_t         oq[$];
  fe_t         fq[$];
  logic [63:0] m_pc;
  bit          m_perr;
  int          cyc, total, bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    oq.delete();
    fq.delete();
    m_pc   = RESET_PC;
    m_perr = 1'b0;
  endtask

  // Entered and left at a negedge: drive, compare, advance model one cycle.
  task automatic step(input bit rv, input bit rr, input bit want_resp, input bit ir, input bit bad_resp);
    bit          resp, exp_rv;
    logic [63:0] rpc;
    logic [31:0] rd;
    oq_t         e;
    cyc++;
    resp = bad_resp || (want_resp && oq.size() > 0 && oq[0].cyc < cyc);
    rpc  = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom_range(0, 15))}
                                      : {$urandom, $urandom};
    rd   = $urandom;
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_req_ready  = rr;
    mem_resp_valid = resp;
    mem_resp_data  = rd;
    inst_ready     = ir;
    #1;
    exp_rv = !rv && (fq.size() + oq.size() < DEPTH);
    chk("req_valid", 64'(mem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", mem_req_addr, m_pc);
    chk("count", 64'(count), 64'(fq.size()));
    chk("inst_valid", 64'(inst_valid), 64'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk("inst_pc", inst_pc, fq[0].pc);
      chk("inst_data", 64'(inst_data), 64'(fq[0].data));
    end
    chk("perr", 64'(protocol_err), 64'(m_perr));
    if (resp && oq.size() == 0) m_perr = 1'b1;
    if (rv) begin
      if (resp && oq.size() > 0) oq.delete(0);
      fq.delete();
      foreach (oq[i]) oq[i].stale = 1'b1;
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (ir && fq.size() != 0) fq.delete(0);
      if (resp && oq.size() > 0) begin
        e = oq.pop_front();
        if (!e.stale) fq.push_back('{e.pc, rd});
      end
      if (exp_rv && rr) begin
        oq.push_back('{m_pc, 1'b0, cyc});
        m_pc = m_pc + 64'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    inst_ready     = 1'b0;
    #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_perr", 64'(protocol_err), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;
    #1;
    chk("por_req_valid", 64'(mem_req_valid), 64'd0);
    chk("por_inst_valid", 64'(inst_valid), 64'd0);
    chk("por_count", 64'(count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Fill: ready memory, latency 1, decoder stalled.
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_no_req", 64'(mem_req_valid), 64'd0);
    // Drain four with refill requests.
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      step($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), 0);
    end

    // Quiesce, then a response with nothing outstanding.
    for (int k = 0; k < 100 && oq.size() > 0; k++) step(0, 0, 1, 1, 0);
    chk("drain_timeout", 64'(oq.size()), 64'd0);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    #1;
    chk("perr_sticky", 64'(protocol_err), 64'd1);
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1'($urandom_range(0, 1)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
